roi_shift_driver: RTL and testbench

Upstream stimulus and readback sequencer for the BRAM ROI shift-register harness. It drives the harness's serial `di`/`stb` inputs: it shifts a DIN_N-bit pattern in, pulses `stb` to latch it into the ROI and capture the ROI outputs, then drains DOUT_N bits from the harness's serial `do` into a 32-bit MISR signature. On-chip logic or a bench can check the signature against a golden value, so no external serial capture is needed.

---
 rtl/roi_shift_driver.sv | 184 ++++++++++++++++++
 tb/tb_roi_shift_driver.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/roi_shift_driver.sv
// Shift-in / strobe / drain sequencer for the BRAM ROI shift-register harness; drained bits fold into a MISR.
// Optional feature macro ROI_DRV_LFSR_EN: LFSR pattern on di (walking one when undefined).
module roi_shift_driver #(
   parameter int unsigned DIN_N  = 256,
   parameter int unsigned DOUT_N = 256,
   parameter logic [31:0] SEED   = 32'h0000_0001,
   parameter logic [15:0] ROUNDS = 16'd1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        di,
   output logic        stb,
   input  logic        do_in,
   output logic        busy,
   output logic        done,
   output logic [15:0] round_cnt,
   output logic [31:0] signature
);

   localparam int unsigned   MAXN      = (DIN_N > DOUT_N) ? DIN_N : DOUT_N;
   localparam int unsigned   CW        = $clog2(MAXN);
   localparam logic [CW-1:0] DIN_LAST  = CW'(DIN_N - 1);
   localparam logic [CW-1:0] DOUT_LAST = CW'(DOUT_N - 1);
   localparam logic [31:0]   MISR_POLY = 32'h04C1_1DB7;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SHIFT = 3'd1,
      S_STB   = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   round_cnt_q, round_cnt_d;
   logic [31:0]   sig_q, sig_d;
   logic          di_q, di_d;
   logic          stb_q, stb_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic          accept;
   logic [15:0]   round_inc;
   // di for the first bit of a run, the next bit within SHIFT, and the first bit of a following round
   logic          accept_di, shift_di, round_di;

   function automatic logic [31:0] misr_step(input logic [31:0] s, input logic b);
      return {s[30:0], 1'b0} ^ (s[31] ? MISR_POLY : 32'd0) ^ {31'd0, b};
   endfunction

   assign accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
   assign round_inc = round_cnt_q + 16'd1;

`ifdef ROI_DRV_LFSR_EN
   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
   localparam logic [31:0] SEED_EFF  = (SEED == 32'd0) ? 32'd1 : SEED;

   logic [31:0] lfsr_q, lfsr_d, lfsr_adv;

   // lfsr_q[0] is always the bit currently (or next) presented on di
   always_comb begin
      lfsr_adv = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_POLY : 32'd0);
      lfsr_d   = lfsr_q;
      if (accept) begin
         lfsr_d = SEED_EFF;
      end else if (state_q == S_SHIFT) begin
         lfsr_d = lfsr_adv;
      end
      accept_di = SEED_EFF[0];
      shift_di  = lfsr_adv[0];
      round_di  = lfsr_q[0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= SEED_EFF;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end
`else
   function automatic logic walk_hit(input logic [CW-1:0] idx, input logic [15:0] rc);
      return {{(32-CW){1'b0}}, idx} == ({16'd0, rc} % DIN_N);
   endfunction

   always_comb begin
      accept_di = 1'b1;
      shift_di  = walk_hit(cnt_q + CW'(1), round_cnt_q);
      round_di  = walk_hit('0, round_inc);
   end
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      round_cnt_d = round_cnt_q;
      sig_d       = sig_q;
      di_d        = 1'b0;
      stb_d       = 1'b0;
      busy_d      = busy_q;
      done_d      = done_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (accept) begin
               state_d     = S_SHIFT;
               cnt_d       = '0;
               round_cnt_d = '0;
               sig_d       = '0;
               di_d        = accept_di;
               busy_d      = 1'b1;
               done_d      = 1'b0;
            end
         end
         S_SHIFT: begin
            if (cnt_q == DIN_LAST) begin
               state_d = S_STB;
               cnt_d   = '0;
               stb_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
               di_d  = shift_di;
            end
         end
         S_STB: begin
            state_d = S_DRAIN;
            cnt_d   = '0;
         end
         S_DRAIN: begin
            sig_d = misr_step(sig_q, do_in);
            if (cnt_q == DOUT_LAST) begin
               round_cnt_d = round_inc;
               cnt_d       = '0;
               if ((ROUNDS != 16'd0) && (round_inc == ROUNDS)) begin
                  state_d = S_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_SHIFT;
                  di_d    = round_di;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         round_cnt_q <= '0;
         sig_q       <= '0;
         di_q        <= 1'b0;
         stb_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         round_cnt_q <= round_cnt_d;
         sig_q       <= sig_d;
         di_q        <= di_d;
         stb_q       <= stb_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign di        = di_q;
   assign stb       = stb_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign round_cnt = round_cnt_q;
   assign signature = sig_q;

endmodule

// File: tb/tb_roi_shift_driver.sv
// Bench for roi_shift_driver with 8-bit chains: u_a uses a looped-back identity harness,
// u_b has do_in tied high, u_c free-runs. Offsets are counted in clock edges from the accepting edge.
`timescale 1ns/1ps
module tb_roi_shift_driver;

   localparam int N = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
   logic di_a, stb_a, do_a, busy_a, done_a;
   logic di_b, stb_b, busy_b, done_b;
   logic di_c, stb_c, busy_c, done_c;
   logic [15:0] rc_a, rc_b, rc_c;
   logic [31:0] sig_a, sig_b, sig_c;
   int t0_a = 0, t0_b = 0, t0_c = 0;

   roi_shift_driver #(.DIN_N(N), .DOUT_N(N), .SEED(32'd0), .ROUNDS(16'd3)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .di(di_a), .stb(stb_a), .do_in(do_a),
      .busy(busy_a), .done(done_a), .round_cnt(rc_a), .signature(sig_a));

   roi_shift_driver #(.DIN_N(N), .DOUT_N(N), .ROUNDS(16'd1)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .di(di_b), .stb(stb_b), .do_in(1'b1),
      .busy(busy_b), .done(done_b), .round_cnt(rc_b), .signature(sig_b));

   roi_shift_driver #(.DIN_N(N), .DOUT_N(N), .ROUNDS(16'd0)) u_c (
      .clk(clk), .rst_n(rst_n), .start(start_c), .di(di_c), .stb(stb_c), .do_in(1'b0),
      .busy(busy_c), .done(done_c), .round_cnt(rc_c), .signature(sig_c));

   // Harness model: input chain shifts every edge, stb copies it (identity ROI) into the output chain
   logic [N-1:0] ha_din  = '0;
   logic [N-1:0] ha_dout = '0;
   always @(posedge clk) begin
      ha_din <= {ha_din[N-2:0], di_a};
      if (stb_a) ha_dout <= ha_din;
      else       ha_dout <= {ha_dout[N-2:0], 1'b0};
   end
   assign do_a = ha_dout[N-1];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input int val);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got event at offset %0d, expected none", name, val);
   endtask

   function automatic logic [31:0] misr_step(input logic [31:0] s, input logic b);
      return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C1_1DB7 : 32'h0) ^ {31'd0, b};
   endfunction

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   // Scoreboards: stb entries {offset, pattern/round}, done entries {round_cnt, signature, offset}
   logic [23:0] exp_stb_a_q[$];
   logic [63:0] exp_done_a_q[$];
   logic [15:0] exp_stb_b_q[$];
   logic [63:0] exp_done_b_q[$];
   logic [31:0] exp_stb_c_q[$];
   logic        mon_c_en = 1'b0;
   logic        done_a_prev = 1'b0, done_b_prev = 1'b0;

   always @(negedge clk) begin
      logic [23:0] es;
      logic [63:0] ed;
      if (stb_a) begin
         if (exp_stb_a_q.size() == 0) fail_now("a_stb_unexpected", cyc - t0_a);
         else begin
            es = exp_stb_a_q.pop_front();
            check("a_stb_offset", 64'(cyc - t0_a), 64'(es[23:8]));
            check("a_pattern", 64'(ha_din), 64'(es[7:0]));
         end
      end
      if (done_a && !done_a_prev) begin
         if (exp_done_a_q.size() == 0) fail_now("a_done_unexpected", cyc - t0_a);
         else begin
            ed = exp_done_a_q.pop_front();
            check("a_done_offset", 64'(cyc - t0_a), 64'(ed[15:0]));
            check("a_round_cnt", 64'(rc_a), 64'(ed[63:48]));
            check("a_signature", 64'(sig_a), 64'(ed[47:16]));
         end
      end
      done_a_prev <= done_a;
   end

   always @(negedge clk) begin
      logic [15:0] es;
      logic [63:0] ed;
      if (stb_b) begin
         if (exp_stb_b_q.size() == 0) fail_now("b_stb_unexpected", cyc - t0_b);
         else begin
            es = exp_stb_b_q.pop_front();
            check("b_stb_offset", 64'(cyc - t0_b), 64'(es));
         end
      end
      if (done_b && !done_b_prev) begin
         if (exp_done_b_q.size() == 0) fail_now("b_done_unexpected", cyc - t0_b);
         else begin
            ed = exp_done_b_q.pop_front();
            check("b_done_offset", 64'(cyc - t0_b), 64'(ed[15:0]));
            check("b_round_cnt", 64'(rc_b), 64'(ed[63:48]));
            check("b_signature", 64'(sig_b), 64'(ed[47:16]));
         end
      end
      done_b_prev <= done_b;
   end

   always @(negedge clk) begin
      logic [31:0] es;
      if (mon_c_en && stb_c) begin
         if (exp_stb_c_q.size() == 0) fail_now("c_stb_unexpected", cyc - t0_c);
         else begin
            es = exp_stb_c_q.pop_front();
            check("c_stb_offset", 64'(cyc - t0_c), 64'(es[31:16]));
            check("c_round_cnt", 64'(rc_c), 64'(es[15:0]));
            check("c_busy", 64'(busy_c), 64'd1);
         end
      end
   end

   // Pushes per-round stb expectations for u_a and returns the expected signature.
   // Walking one over 3 rounds drains 0x80,0x40,0x20, i.e. signature 0x0080_4020.
   task automatic push_model_a(input int rounds, output logic [31:0] sig_o);
      logic [N-1:0] pat;
`ifdef ROI_DRV_LFSR_EN
      logic [31:0] lf;
      lf = 32'd1;
`endif
      sig_o = '0;
      for (int r = 0; r < rounds; r++) begin
`ifdef ROI_DRV_LFSR_EN
         for (int k = 0; k < N; k++) begin
            pat[N-1-k] = lf[0];
            lf = lfsr_step(lf);
         end
`else
         pat = 8'h80 >> r;
`endif
         for (int k = 0; k < N; k++) sig_o = misr_step(sig_o, pat[N-1-k]);
         exp_stb_a_q.push_back({16'(8 + 17 * r), pat});
      end
   endtask

   task automatic accept_a();
      @(negedge clk);
      start_a = 1'b1;
      t0_a    = cyc + 1;
      @(negedge clk);
      start_a = 1'b0;
   endtask

   task automatic poke_a(input int k);
      while (cyc - t0_a < k) @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
   endtask

   initial begin
      logic [31:0] sig_m;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_di", 64'(di_a), 64'd0);
      check("rst_stb", 64'(stb_a), 64'd0);
      check("rst_busy", 64'(busy_a), 64'd0);
      check("rst_done", 64'(done_a), 64'd0);
      check("rst_round_cnt", 64'(rc_a), 64'd0);
      check("rst_signature", 64'(sig_a), 64'd0);
      check("rst_b_busy", 64'(busy_b), 64'd0);
      check("rst_c_done", 64'(done_c), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_busy", 64'(busy_a), 64'd0);

      // Reset in the middle of the first DRAIN
      push_model_a(1, sig_m);
      accept_a();
      while (cyc - t0_a < 12) @(negedge clk);
      check("a_busy_mid_drain", 64'(busy_a), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_di", 64'(di_a), 64'd0);
      check("mid_rst_stb", 64'(stb_a), 64'd0);
      check("mid_rst_busy", 64'(busy_a), 64'd0);
      check("mid_rst_done", 64'(done_a), 64'd0);
      check("mid_rst_round_cnt", 64'(rc_a), 64'd0);
      check("mid_rst_signature", 64'(sig_a), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      check("a_stb_left_after_rst", 64'(exp_stb_a_q.size()), 64'd0);
      exp_stb_a_q.delete();
      exp_done_a_q.delete();

      // Full 3-round run with start pulsed in SHIFT, STB, DRAIN and the next SHIFT
      push_model_a(3, sig_m);
      exp_done_a_q.push_back({16'd3, sig_m, 16'd51});
      accept_a();
      poke_a(3);
      poke_a(8);
      poke_a(12);
      poke_a(20);
      for (int i = 0; i < 200 && !done_a; i++) @(negedge clk);
      check("a_done_reached", 64'(done_a), 64'd1);
      @(negedge clk);
      check("a_stb_left", 64'(exp_stb_a_q.size()), 64'd0);
      check("a_done_left", 64'(exp_done_a_q.size()), 64'd0);
      repeat (3) @(negedge clk);
      check("a_done_held", 64'(done_a), 64'd1);
      check("a_sig_stable", 64'(sig_a), 64'(sig_m));
      check("a_rc_stable", 64'(rc_a), 64'd3);

      // do_in tied high: eight MISR steps of ones from zero give 0xFF
      exp_stb_b_q.push_back(16'd8);
      exp_done_b_q.push_back({16'd1, 32'h0000_00FF, 16'd17});
      @(negedge clk);
      start_b = 1'b1;
      t0_b    = cyc + 1;
      @(negedge clk);
      start_b = 1'b0;
      for (int i = 0; i < 100 && !done_b; i++) @(negedge clk);
      check("b_done_reached", 64'(done_b), 64'd1);
      @(negedge clk);
      check("b_queue_left", 64'(exp_stb_b_q.size() + exp_done_b_q.size()), 64'd0);

      // start held high: immediate restart, done lasts one cycle
      exp_stb_b_q.push_back(16'd8);
      exp_done_b_q.push_back({16'd1, 32'h0000_00FF, 16'd17});
      exp_stb_b_q.push_back(16'd26);
      exp_done_b_q.push_back({16'd1, 32'h0000_00FF, 16'd35});
      start_b = 1'b1;
      t0_b    = cyc + 1;
      while (cyc - t0_b < 17) @(negedge clk);
      check("b_done_set", 64'(done_b), 64'd1);
      @(negedge clk);
      check("b_done_one_cycle", 64'(done_b), 64'd0);
      check("b_busy_restart", 64'(busy_b), 64'd1);
      start_b = 1'b0;
      while (cyc - t0_b < 36) @(negedge clk);
      check("b_queue_left2", 64'(exp_stb_b_q.size() + exp_done_b_q.size()), 64'd0);
      check("b_done_final", 64'(done_b), 64'd1);

      // ROUNDS=0 keeps running
      for (int r = 0; r < 5; r++) exp_stb_c_q.push_back({16'(8 + 17 * r), 16'(r)});
      mon_c_en = 1'b1;
      @(negedge clk);
      start_c = 1'b1;
      t0_c    = cyc + 1;
      @(negedge clk);
      start_c = 1'b0;
      for (int i = 0; i < 200 && exp_stb_c_q.size() != 0; i++) @(negedge clk);
      mon_c_en = 1'b0;
      check("c_queue_left", 64'(exp_stb_c_q.size()), 64'd0);
      repeat (5) @(negedge clk);
      check("c_busy_after", 64'(busy_c), 64'd1);
      check("c_done_after", 64'(done_c), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
